// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM encoding, word/field geometry and reset PC for the fetch unit.
package instr_fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, NEXT} fetch_state_t;
    localparam int WORD_W = 16;
    localparam int TGT_W = 12;
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;
    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc,
                                                   input logic jump,
                                                   input logic [TGT_W-1:0] target);
        return jump ? {pc[WORD_W-1:TGT_W], target} : pc + 16'd1;
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read bus between the fetch unit (master) and memory (slave).
interface instr_fetch_if;
    import instr_fetch_pkg::*;
    logic              readM;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
    logic              inputReady;
    modport master(output readM, address, input data, inputReady);
    modport slave(input readM, address, output data, inputReady);
endinterface

// File: rtl/instr_fetch_pc_unit.sv
// pc_unit: program counter register with increment/jump next-PC selection.
module pc_unit
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              jump,
    input  logic [TGT_W-1:0]  target,
    output logic [WORD_W-1:0] pc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else if (load) pc <= next_pc(pc, jump, target);
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: FETCH/HOLD/NEXT instruction fetch FSM with IR decode.
// Optional INSTR_COUNT_EN adds the num_inst consumed-instruction counter.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     mem,
    input  logic              advance,
    input  logic              jump,
    input  logic [TGT_W-1:0]  target,
    output logic [WORD_W-1:0] pc,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [5:0]        function_code,
    output logic [1:0]        rs,
    output logic [1:0]        rt,
    output logic [1:0]        rd,
    output logic [7:0]        imm
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]       num_inst
`endif
);
    fetch_state_t      state;
    logic [WORD_W-1:0] ir;
    logic              read_m;
    logic              accept;
    assign accept = (state == HOLD) && advance;
    pc_unit u_pc (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .jump(jump),
        .target(target),
        .pc(pc)
    );
    // Reset parks in NEXT so the first post-reset edge raises readM at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NEXT;
            ir <= '0;
            read_m <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: if (mem.inputReady) begin
                    ir <= mem.data;
                    read_m <= 1'b0;
                    instr_valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: if (advance) begin
                    instr_valid <= 1'b0;
                    state <= NEXT;
                end
                default: begin
                    read_m <= 1'b1;
                    state <= FETCH;
                end
            endcase
        end
    end
`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) num_inst <= '0;
        else if (accept) num_inst <= num_inst + 16'd1;
    end
`endif
    assign mem.readM = read_m;
    assign mem.address = pc;
    assign opcode = ir[OP_MSB:OP_LSB];
    assign function_code = ir[FN_MSB:FN_LSB];
    assign rs = ir[11:10];
    assign rt = ir[9:8];
    assign rd = ir[7:6];
    assign imm = ir[7:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch (set INSTR_COUNT_EN to cover num_inst).
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        advance = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] target = 12'h000;
    logic [15:0] pc;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [5:0]  function_code;
    logic [1:0]  rs, rt, rd;
    logic [7:0]  imm;
`ifdef INSTR_COUNT_EN
    logic [15:0] num_inst;
`endif
    int tests = 0;
    int fails = 0;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk(clk),
        .reset(reset),
        .mem(bus.master),
        .advance(advance),
        .jump(jump),
        .target(target),
        .pc(pc),
        .instr_valid(instr_valid),
        .opcode(opcode),
        .function_code(function_code),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .imm(imm)
`ifdef INSTR_COUNT_EN
        ,
        .num_inst(num_inst)
`endif
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a read request, then answer it in that cycle.
    task automatic fetch(input logic [15:0] d);
        int n = 0;
        while (bus.readM !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.readM !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL fetch_timeout readM=%b required 1", bus.readM);
        end
        bus.data = d;
        bus.inputReady = 1'b1;
        @(negedge clk);
        bus.inputReady = 1'b0;
    endtask

    task automatic do_advance(input logic j, input logic [11:0] t);
        advance = 1'b1;
        jump = j;
        target = t;
        @(negedge clk);
        advance = 1'b0;
        jump = 1'b0;
        target = 12'h000;
    endtask

    task automatic step(input logic j, input logic [11:0] t);
        fetch(16'h0000);
        do_advance(j, t);
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.data = 16'h0000;
        bus.inputReady = 1'b0;
        #1;
        tests++;
        if (bus.readM !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000 || opcode !== 4'h0) begin
            fails++;
            $display("FAIL reset_state readM=%b valid=%b pc=%h op=%h required 0/0/0000/0",
                     bus.readM, instr_valid, pc, opcode);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (bus.readM !== 1'b0) begin
            fails++;
            $display("FAIL reset_held readM=%b required 0", bus.readM);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_fetch;
        int highs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.readM === 1'b1 && bus.address === 16'h0000) highs++;
        end
        tests++;
        if (highs != 3) begin
            fails++;
            $display("FAIL first_fetch_readm highs=%0d required 3", highs);
        end
        bus.data = 16'h4A05;
        bus.inputReady = 1'b1;
        @(negedge clk);
        bus.inputReady = 1'b0;
        tests++;
        if (bus.readM !== 1'b0 || instr_valid !== 1'b1 || opcode !== 4'h4 || imm !== 8'h05
            || function_code !== 6'h05 || rs !== 2'b10 || rt !== 2'b10 || rd !== 2'b00) begin
            fails++;
            $display("FAIL first_fetch_decode readM=%b valid=%b op=%h imm=%h fn=%h rs=%b rt=%b rd=%b required 0/1/4/05/05/10/10/00",
                     bus.readM, instr_valid, opcode, imm, function_code, rs, rt, rd);
        end
    endtask

    task automatic test_hold_ignore;
        bus.data = 16'h1234;
        bus.inputReady = 1'b1;
        repeat (2) @(negedge clk);
        bus.inputReady = 1'b0;
        tests++;
        if (opcode !== 4'h4 || imm !== 8'h05 || instr_valid !== 1'b1 || pc !== 16'h0000 || bus.readM !== 1'b0) begin
            fails++;
            $display("FAIL hold_stable op=%h imm=%h valid=%b pc=%h readM=%b required 4/05/1/0000/0",
                     opcode, imm, instr_valid, pc, bus.readM);
        end
    endtask

    task automatic test_increment;
        do_advance(1'b1, 12'h010);
        @(negedge clk);
        fetch(16'h0000);
        do_advance(1'b0, 12'h000);
        tests++;
        if (pc !== 16'h0011 || bus.readM !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL incr_next pc=%h readM=%b valid=%b required 0011/0/0", pc, bus.readM, instr_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.readM !== 1'b1 || bus.address !== 16'h0011) begin
            fails++;
            $display("FAIL incr_refetch readM=%b addr=%h required 1/0011", bus.readM, bus.address);
        end
        do_advance(1'b1, 12'h777);
        tests++;
        if (pc !== 16'h0011 || bus.readM !== 1'b1) begin
            fails++;
            $display("FAIL advance_in_fetch pc=%h readM=%b required 0011/1", pc, bus.readM);
        end
    endtask

    task automatic test_jump;
        for (int h = 0; h < 3; h++) begin
            step(1'b1, 12'hFFF);
            step(1'b0, 12'h000);
        end
        step(1'b1, 12'hABC);
        tests++;
        if (bus.readM !== 1'b1 || bus.address !== 16'h3ABC) begin
            fails++;
            $display("FAIL walk_to_3abc readM=%b addr=%h required 1/3abc", bus.readM, bus.address);
        end
        step(1'b1, 12'h123);
        tests++;
        if (bus.readM !== 1'b1 || bus.address !== 16'h3123) begin
            fails++;
            $display("FAIL jump_target readM=%b addr=%h required 1/3123", bus.readM, bus.address);
        end
    endtask

    task automatic test_wrap;
        for (int h = 3; h < 15; h++) begin
            step(1'b1, 12'hFFF);
            step(1'b0, 12'h000);
        end
        step(1'b1, 12'hFFF);
        tests++;
        if (bus.address !== 16'hFFFF) begin
            fails++;
            $display("FAIL walk_to_ffff addr=%h required ffff", bus.address);
        end
        step(1'b0, 12'h000);
        tests++;
        if (bus.readM !== 1'b1 || bus.address !== 16'h0000) begin
            fails++;
            $display("FAIL pc_wrap readM=%b addr=%h required 1/0000", bus.readM, bus.address);
        end
    endtask

    task automatic test_reset_mid_fetch;
        fetch(16'hBEEF);
        do_advance(1'b0, 12'h000);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bus.readM !== 1'b0 || pc !== 16'h0000 || instr_valid !== 1'b0 || opcode !== 4'h0 || imm !== 8'h00) begin
            fails++;
            $display("FAIL reset_async readM=%b pc=%h valid=%b op=%h imm=%h required 0/0000/0/0/00",
                     bus.readM, pc, instr_valid, opcode, imm);
        end
        bus.data = 16'hFFFF;
        bus.inputReady = 1'b1;
        @(negedge clk);
        bus.inputReady = 1'b0;
        reset = 1'b0;
        tests++;
        if (opcode !== 4'h0 || imm !== 8'h00 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ignore_data op=%h imm=%h valid=%b required 0/00/0", opcode, imm, instr_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.readM !== 1'b1 || bus.address !== 16'h0000) begin
            fails++;
            $display("FAIL reset_restart readM=%b addr=%h required 1/0000", bus.readM, bus.address);
        end
    endtask

    task automatic test_count;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef INSTR_COUNT_EN
        tests++;
        if (num_inst !== 16'd0) begin
            fails++;
            $display("FAIL count_reset num_inst=%0d required 0", num_inst);
        end
`endif
        for (int i = 0; i < 5; i++) step(1'b0, 12'h000);
        tests++;
        if (bus.address !== 16'h0005) begin
            fail_note("count_addr", bus.address, 16'h0005);
        end
`ifdef INSTR_COUNT_EN
        tests++;
        if (num_inst !== 16'd5) begin
            fails++;
            $display("FAIL count_five num_inst=%0d required 5", num_inst);
        end
`endif
    endtask

    task automatic fail_note(input string name, input logic [15:0] got, input logic [15:0] want);
        fails++;
        $display("FAIL %s got=%h required %h", name, got, want);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_ignore();
        test_increment();
        test_jump();
        test_wrap();
        test_reset_mid_fetch();
        test_count();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
